// File: rtl/elevator_call_scheduler.sv
// Single-car collective (SCAN) elevator call scheduler.
// Latches floor calls, moves one floor per MOVE_TICKS cycles, holds the door
// open for DOOR_TICKS cycles, and keeps travelling in the current direction
// while calls remain ahead of the car.
module elevator_call_scheduler #(
    parameter int unsigned NUM_FLOORS = 10,
    parameter int unsigned MOVE_TICKS = 100000,
    parameter int unsigned DOOR_TICKS = 200000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_req,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [3:0]            current_floor,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open,
    output logic                  idle
);

    localparam int unsigned MW = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;
    localparam int unsigned DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR_OPEN
    } state_t;

    state_t                  state;
    logic [MW-1:0]           move_cnt;
    logic [DW-1:0]           door_cnt;

    logic [NUM_FLOORS-1:0]   cur_bit;
    logic [NUM_FLOORS-1:0]   arr_bit;
    logic [NUM_FLOORS-1:0]   set_mask;
    logic [NUM_FLOORS-1:0]   clr_mask;
    logic [NUM_FLOORS-1:0]   pending_nxt;
    logic [3:0]              arr_floor;
    logic                    above;
    logic                    below;
    logic                    here;
    logic                    arr_hit;
    logic                    arr_continue;
    logic                    move_tc;
    logic                    door_tc;
    logic                    door_recall;

    function automatic logic has_above(input logic [NUM_FLOORS-1:0] p,
                                       input logic [3:0] f);
        logic r;
        r = 1'b0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (p[i] && (i > 32'(f))) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic has_below(input logic [NUM_FLOORS-1:0] p,
                                       input logic [3:0] f);
        logic r;
        r = 1'b0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (p[i] && (i < 32'(f))) r = 1'b1;
        end
        return r;
    endfunction

    assign moving    = (state == MOVE_UP) || (state == MOVE_DOWN);
    assign door_open = (state == DOOR_OPEN);
    assign idle      = (state == IDLE);

    // Decision terms and the next pending set, all derived from registered state.
    always_comb begin
        cur_bit      = NUM_FLOORS'(1) << current_floor;
        arr_floor    = (state == MOVE_DOWN) ? (current_floor - 4'd1)
                                            : (current_floor + 4'd1);
        arr_bit      = NUM_FLOORS'(1) << arr_floor;
        above        = has_above(pending, current_floor);
        below        = has_below(pending, current_floor);
        here         = |(pending & cur_bit);
        arr_hit      = |(pending & arr_bit);
        arr_continue = (state == MOVE_DOWN) ? has_below(pending, arr_floor)
                                            : has_above(pending, arr_floor);
        move_tc      = (move_cnt == MW'(MOVE_TICKS - 1));
        door_tc      = (door_cnt == DW'(DOOR_TICKS - 1));
        door_recall  = |(call_req & cur_bit);

        // A call for the floor whose door is open only re-arms the door timer.
        set_mask = call_req;
        if (state == DOOR_OPEN) set_mask = call_req & ~cur_bit;

        clr_mask = '0;
        if (state == IDLE && here) begin
            clr_mask = cur_bit;
        end else if (moving && move_tc && arr_hit) begin
            clr_mask = arr_bit;
        end

        pending_nxt = (pending | set_mask) & ~clr_mask;
    end

    // Car state machine, position, direction, timers and call latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pending       <= '0;
            current_floor <= '0;
            dir_up        <= 1'b1;
            move_cnt      <= '0;
            door_cnt      <= '0;
        end else begin
            pending <= pending_nxt;
            case (state)
                IDLE: begin
                    if (here) begin
                        state    <= DOOR_OPEN;
                        door_cnt <= '0;
                    end else if (above && (dir_up || !below)) begin
                        state    <= MOVE_UP;
                        dir_up   <= 1'b1;
                        move_cnt <= '0;
                    end else if (below) begin
                        state    <= MOVE_DOWN;
                        dir_up   <= 1'b0;
                        move_cnt <= '0;
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    if (move_tc) begin
                        move_cnt      <= '0;
                        current_floor <= arr_floor;
                        // Arrival is judged against the floor just reached.
                        if (arr_hit) begin
                            state    <= DOOR_OPEN;
                            door_cnt <= '0;
                        end else if (!arr_continue) begin
                            state <= IDLE;
                        end
                    end else begin
                        move_cnt <= move_cnt + 1'b1;
                    end
                end
                DOOR_OPEN: begin
                    if (door_recall) begin
                        door_cnt <= '0;
                    end else if (door_tc) begin
                        door_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        door_cnt <= door_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Self-checking bench for elevator_call_scheduler (MOVE_TICKS=4, DOOR_TICKS=3).
module tb_elevator_call_scheduler;

    logic       clk;
    logic       rst;
    logic [9:0] call_req;
    logic [9:0] pending;
    logic [3:0] current_floor;
    logic       dir_up;
    logic       moving;
    logic       door_open;
    logic       idle;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_q[$];
    logic       door_q = 1'b0;

    typedef struct {
        logic [9:0]  calls;
        int          nstops;
        logic [39:0] stops;      // nibble i = i-th floor where the door opens
        logic [3:0]  end_floor;
        logic        end_dir;
    } vec_t;

    vec_t vec[7];

    elevator_call_scheduler #(
        .NUM_FLOORS(10),
        .MOVE_TICKS(4),
        .DOOR_TICKS(3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .call_req      (call_req),
        .pending       (pending),
        .current_floor (current_floor),
        .dir_up        (dir_up),
        .moving        (moving),
        .door_open     (door_open),
        .idle          (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every door opening must match the next expected stop.
    always @(negedge clk) begin
        if (door_open === 1'b1 && !door_q) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_door: got floor=%0d want no door", current_floor);
            end else begin
                check("stop_floor", 32'(current_floor), 32'(exp_q.pop_front()));
            end
        end
        door_q = (door_open === 1'b1);
    end

    task automatic wait_settle(input string name, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (idle && pending == 10'h000 && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({name, "_settle"}, 32'(ok), 32'd1);
        exp_q.delete();
    endtask

    task automatic wait_floor(input string name, input logic [3:0] target, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (current_floor == target) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_reach"}, 32'(ok), 32'd1);
    endtask

    task automatic do_reset(input logic [9:0] calls_during);
        rst      = 1'b1;
        call_req = calls_during;
        repeat (2) @(negedge clk);
        check("rst_idle",    32'(idle),          32'd1);
        check("rst_floor",   32'(current_floor), 32'd0);
        check("rst_pending", 32'(pending),       32'd0);
        check("rst_dir",     32'(dir_up),        32'd1);
        check("rst_moving",  32'(moving),        32'd0);
        check("rst_door",    32'(door_open),     32'd0);
        rst      = 1'b0;
        call_req = '0;
    endtask

    initial begin
        vec[0] = '{calls: 10'h081, nstops: 2,  stops: 40'h0000000007, end_floor: 4'd0, end_dir: 1'b0};
        vec[1] = '{calls: 10'h001, nstops: 1,  stops: 40'h0000000000, end_floor: 4'd0, end_dir: 1'b0};
        vec[2] = '{calls: 10'h3FF, nstops: 10, stops: 40'h9876543210, end_floor: 4'd9, end_dir: 1'b1};
        vec[3] = '{calls: 10'h024, nstops: 2,  stops: 40'h0000000025, end_floor: 4'd2, end_dir: 1'b0};
        vec[4] = '{calls: 10'h202, nstops: 2,  stops: 40'h0000000091, end_floor: 4'd9, end_dir: 1'b1};
        vec[5] = '{calls: 10'h010, nstops: 1,  stops: 40'h0000000004, end_floor: 4'd4, end_dir: 1'b0};
        vec[6] = '{calls: 10'h2B0, nstops: 4,  stops: 40'h0000009754, end_floor: 4'd9, end_dir: 1'b1};

        rst      = 1'b1;
        call_req = '0;
        do_reset(10'h3FF);

        // Single call to floor 3: latency, travel timing, door length.
        call_req = 10'h008;
        exp_q.push_back(4'd3);
        @(negedge clk);
        check("a_pending", 32'(pending), 32'h008);
        check("a_idle",    32'(idle),    32'd1);
        call_req = '0;
        @(negedge clk);
        check("a_moving", 32'(moving),        32'd1);
        check("a_floor0", 32'(current_floor), 32'd0);
        for (int f = 1; f <= 3; f++) begin
            repeat (3) @(negedge clk);
            check($sformatf("a_hold%0d", f), 32'(current_floor), 32'(f - 1));
            @(negedge clk);
            check($sformatf("a_step%0d", f), 32'(current_floor), 32'(f));
        end
        check("a_door0", 32'(door_open), 32'd1);
        check("a_pclr",  32'(pending),   32'd0);
        repeat (2) begin
            @(negedge clk);
            check("a_door_hold", 32'(door_open), 32'd1);
        end
        @(negedge clk);
        check("a_door_close", 32'(door_open), 32'd0);
        check("a_idle_end",   32'(idle),      32'd1);
        check("a_pend_end",   32'(pending),   32'd0);

        // Door re-call at floor 3 held for two cycles extends the door.
        call_req = 10'h008;
        exp_q.push_back(4'd3);
        @(negedge clk);
        call_req = '0;
        @(negedge clk);
        check("c_door", 32'(door_open), 32'd1);
        call_req = 10'h008;
        repeat (2) begin
            @(negedge clk);
            check("c_door_req", 32'(door_open), 32'd1);
            check("c_pend3",    32'(pending),   32'd0);
        end
        call_req = '0;
        repeat (2) begin
            @(negedge clk);
            check("c_door_ext", 32'(door_open), 32'd1);
            check("c_pend3b",   32'(pending),   32'd0);
        end
        @(negedge clk);
        check("c_door_close", 32'(door_open), 32'd0);
        check("c_idle",       32'(idle),      32'd1);

        // Table-driven call patterns starting idle at floor 3, dir up.
        for (int v = 0; v < 7; v++) begin
            call_req = vec[v].calls;
            for (int s = 0; s < vec[v].nstops; s++) exp_q.push_back(vec[v].stops[s*4 +: 4]);
            @(negedge clk);
            call_req = '0;
            wait_settle($sformatf("v%0d", v), 400);
            check($sformatf("v%0d_floor", v),   32'(current_floor), 32'(vec[v].end_floor));
            check($sformatf("v%0d_dir", v),     32'(dir_up),        32'(vec[v].end_dir));
            check($sformatf("v%0d_pending", v), 32'(pending),       32'd0);
        end

        // Collective pickup: heading to 8, calls for 6 and 2 while passing 5.
        do_reset(10'h000);
        call_req = 10'h100;
        @(negedge clk);
        call_req = '0;
        wait_floor("b5", 4'd5, 100);
        check("b_moving", 32'(moving), 32'd1);
        check("b_dir",    32'(dir_up), 32'd1);
        call_req = 10'h044;
        exp_q.push_back(4'd6);
        exp_q.push_back(4'd8);
        exp_q.push_back(4'd2);
        @(negedge clk);
        call_req = '0;
        wait_settle("b", 400);
        check("b_floor", 32'(current_floor), 32'd2);
        check("b_dir_end", 32'(dir_up), 32'd0);

        // Reset in the middle of a move between floors 2 and 3.
        do_reset(10'h000);
        call_req = 10'h1F0;
        @(negedge clk);
        call_req = '0;
        wait_floor("d2", 4'd2, 100);
        @(negedge clk);
        check("d_pending", 32'(pending), 32'h1F0);
        check("d_moving",  32'(moving),  32'd1);
        rst      = 1'b1;
        call_req = 10'h3FF;
        @(negedge clk);
        check("d_floor",   32'(current_floor), 32'd0);
        check("d_pclr",    32'(pending),       32'd0);
        check("d_idle",    32'(idle),          32'd1);
        check("d_dir",     32'(dir_up),        32'd1);
        check("d_moving0", 32'(moving),        32'd0);
        call_req = 10'h020;
        @(negedge clk);
        check("d_ign", 32'(pending), 32'd0);
        rst = 1'b0;
        exp_q.push_back(4'd5);
        @(negedge clk);
        check("d_resume", 32'(pending), 32'h020);
        call_req = '0;
        wait_settle("d", 400);
        check("d_floor_end", 32'(current_floor), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/elevator_call_scheduler.md
ELEVATOR_CALL_SCHEDULER -- requirements
Module: elevator_call_scheduler

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 10, number of served floors (0..NUM_FLOORS-1, NUM_FLOORS <= 16).
REQ-002 SHALL have parameter MOVE_TICKS, default 100000, clock cycles to travel one floor.
REQ-003 SHALL have parameter DOOR_TICKS, default 200000, clock cycles the door stays open.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port call_req  input  NUM_FLOORS  floor call buttons, bit i = call for floor i, level-sampled every cycle.
REQ-007 SHALL have port pending  output  NUM_FLOORS  registered set of outstanding calls.
REQ-008 SHALL have port current_floor  output  4  registered car position, suitable for the 7-segment decoder.
REQ-009 SHALL have port dir_up  output  1  registered travel direction, 1 = up.
REQ-010 SHALL have port moving  output  1  high in MOVE_UP/MOVE_DOWN.
REQ-011 SHALL have port door_open  output  1  high in DOOR_OPEN.
REQ-012 SHALL have port idle  output  1  high in IDLE.

Function
REQ-013 SHALL implement states IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN; moving/door_open/idle decoded from registered state only.
REQ-014 SHALL update pending each cycle as pending | call_req, minus any bit cleared that cycle; clear wins over set for the same bit.
REQ-015 SHALL base all decisions on registered pending: call_req at cycle N visible in pending at N+1, first state change at N+2.
REQ-016 SHALL define above = any pending bit > current_floor, below = any pending bit < current_floor.
REQ-017 IDLE: pending[current_floor] -> DOOR_OPEN, clear that bit, door counter 0; else above and (dir_up or not below) -> MOVE_UP, dir_up=1; else below -> MOVE_DOWN, dir_up=0; else stay IDLE.
REQ-018 MOVE_UP/MOVE_DOWN: move counter counts 0..MOVE_TICKS-1; on terminal count current_floor increments/decrements by 1 and counter returns to 0.
REQ-019 On arrival (terminal-count cycle), evaluated against the new floor: pending[new] -> DOOR_OPEN with that bit cleared; else continuing direction has pending floors -> stay moving; else -> IDLE.
REQ-020 SHALL never move below floor 0 or above NUM_FLOORS-1; guaranteed by REQ-016/017/019, no wrap-around permitted.
REQ-021 DOOR_OPEN: door counter counts 0..DOOR_TICKS-1, then -> IDLE.
REQ-022 In DOOR_OPEN, call_req[current_floor]=1 SHALL restart door counter to 0 and SHALL NOT set pending[current_floor].
REQ-023 Calls for other floors SHALL be latched in every state, including while moving and door open.
REQ-024 dir_up SHALL change only on IDLE->MOVE_* transitions (SCAN/collective behaviour).
REQ-025 call_req bits for floors >= NUM_FLOORS do not exist; counters sized to hold MOVE_TICKS-1 and DOOR_TICKS-1.

Reset
REQ-026 rst=1 at a rising edge SHALL force state IDLE, pending=0, current_floor=0, dir_up=1, moving=0, door_open=0, idle=1, both counters 0, regardless of state or call_req.
REQ-027 Reset mid-move or mid-door SHALL abort the operation immediately; no partial floor update or latched call survives.
REQ-028 Calls presented during reset SHALL be ignored; latching resumes the first cycle rst=0.

Verification (bench uses MOVE_TICKS=4, DOOR_TICKS=3, NUM_FLOORS=10)
REQ-029 Reset, call_req=bit3 one cycle -> pending=0x008 next cycle, moving next, current_floor 1,2,3 at 4-cycle intervals, door_open 3 cycles at floor 3, pending=0, idle=1.
REQ-030 Idle at floor 0, call_req=bit0 -> door_open without moving, current_floor stays 0, pending returns 0.
REQ-031 Moving up at floor 5 toward 8, call floors 6 and 2 -> stops at 6, then 8, then dir_up=0 and travels down to stop at 2.
REQ-032 During DOOR_OPEN at floor 3, hold call_req=bit3 for 2 cycles -> door open extended to 3 cycles past last request, pending[3] stays 0.
REQ-033 rst pulsed during MOVE_UP between floors 2 and 3 with pending=0x1F0 -> next cycle current_floor=0, pending=0, idle=1, dir_up=1.
REQ-034 Idle at floor 0, call_req=0x3FF one cycle -> door opens at every floor 0..9 in order, never reverses, ends idle at 9 with pending=0.
